// File: rtl/hb_monitor_if.sv
// rtl/hb_monitor_if.sv - control/status bundle of the heartbeat link monitor
//
// Purpose: groups the link-condition inputs, the received command and the
//          monitor status outputs into one bundle.
// Signals:
//   pcs_reset, mr_autoneg_enable, an_link_good, multidrop - link conditions
//   rx_cmd[1:0]      - received command (00 BEACON, 01 COMMIT, 10 HEARTBEAT, 11 NONE)
//   mon_state[2:0]   - monitor state encoding
//   hb_link_ok       - remote heartbeat present
//   hb_fault         - one-cycle pulse on entry to LINK_FAIL
//   hb_miss_cnt[3:0] - consecutive timeouts, saturating at MISS_LIMIT
//   hb_rx_count[15:0]- heartbeat event count (0 unless statistics are built in)
// Modports: master drives the inputs and observes status; slave is the monitor.

interface hb_monitor_if;
   logic        pcs_reset;
   logic        mr_autoneg_enable;
   logic        an_link_good;
   logic        multidrop;
   logic [1:0]  rx_cmd;
   logic [2:0]  mon_state;
   logic        hb_link_ok;
   logic        hb_fault;
   logic [3:0]  hb_miss_cnt;
   logic [15:0] hb_rx_count;

   modport master (
      output pcs_reset, mr_autoneg_enable, an_link_good, multidrop, rx_cmd,
      input  mon_state, hb_link_ok, hb_fault, hb_miss_cnt, hb_rx_count
   );

   modport slave (
      input  pcs_reset, mr_autoneg_enable, an_link_good, multidrop, rx_cmd,
      output mon_state, hb_link_ok, hb_fault, hb_miss_cnt, hb_rx_count
   );
endinterface

// File: rtl/hb_monitor.sv
// rtl/hb_monitor.sv - heartbeat link monitor with miss counting and fault pulse
//
// Purpose: watches received HEARTBEAT commands, times the silence between
//          them and walks INIT/WAIT_FIRST/LINK_OK/MISSING/LINK_FAIL/DISABLED.
// Parameters:
//   HB_TIMEOUT - cycles of silence that count as one miss (2..65535)
//   MISS_LIMIT - consecutive misses that declare link failure (1..15)
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   mon   - hb_monitor_if.slave: link conditions and rx_cmd in, status out
// Build option: define HB_MON_STATS_EN to include the hb_rx_count counter;
//   otherwise hb_rx_count is tied to 0.

module hb_monitor #(
   parameter logic [15:0] HB_TIMEOUT = 16'd1000,
   parameter logic [3:0]  MISS_LIMIT = 4'd3
) (
   input  logic         clk,
   input  logic         rst_n,
   hb_monitor_if.slave  mon
);

   typedef enum logic [2:0] {
      ST_INIT       = 3'b000,
      ST_WAIT_FIRST = 3'b001,
      ST_LINK_OK    = 3'b010,
      ST_MISSING    = 3'b011,
      ST_LINK_FAIL  = 3'b100,
      ST_DISABLED   = 3'b101
   } state_t;

   localparam logic [1:0]  CMD_BEACON    = 2'b00;
   localparam logic [1:0]  CMD_HEARTBEAT = 2'b10;
   localparam logic [15:0] TIMER_LAST    = HB_TIMEOUT - 16'd1;

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [3:0]  miss_q, miss_d;
   logic        hb_lvl_q, hb_lvl_d;
   logic        hb_evt_q, hb_evt_d;
   logic        link_ok_q, link_ok_d;
   logic        fault_q, fault_d;

   logic        enable;
   logic        timeout;
   logic        timer_run;

   always_comb begin
      enable  = !mon.pcs_reset && mon.mr_autoneg_enable && mon.an_link_good && !mon.multidrop;
      timeout = (timer_q == TIMER_LAST);

      // Edge detect on the HEARTBEAT level so a held command counts once.
      hb_lvl_d = (mon.rx_cmd == CMD_HEARTBEAT);
      hb_evt_d = hb_lvl_d && !hb_lvl_q;

      state_d = state_q;
      miss_d  = miss_q;

      if (!enable) begin
         state_d = ST_INIT;
      end else if (mon.rx_cmd == CMD_BEACON) begin
         state_d = ST_DISABLED;
      end else begin
         unique case (state_q)
            ST_INIT: begin
               state_d = ST_WAIT_FIRST;
               miss_d  = 4'd0;
            end
            ST_WAIT_FIRST: begin
               if (hb_evt_q) state_d = ST_LINK_OK;
            end
            ST_LINK_OK: begin
               // A heartbeat landing on the timeout cycle wins.
               if (!hb_evt_q && timeout) begin
                  miss_d  = 4'd1;
                  state_d = (MISS_LIMIT == 4'd1) ? ST_LINK_FAIL : ST_MISSING;
               end
            end
            ST_MISSING: begin
               if (hb_evt_q) begin
                  state_d = ST_LINK_OK;
                  miss_d  = 4'd0;
               end else if (timeout) begin
                  if (miss_q + 4'd1 >= MISS_LIMIT) begin
                     state_d = ST_LINK_FAIL;
                     miss_d  = MISS_LIMIT;
                  end else begin
                     miss_d  = miss_q + 4'd1;
                  end
               end
            end
            ST_LINK_FAIL: begin
               if (hb_evt_q) begin
                  state_d = ST_LINK_OK;
                  miss_d  = 4'd0;
               end
            end
            ST_DISABLED: begin
               state_d = ST_DISABLED;
            end
            default: begin
               state_d = ST_INIT;
            end
         endcase
      end

      // Timer only runs in the watching states and restarts on every event or miss.
      timer_run = (state_q == ST_WAIT_FIRST) || (state_q == ST_LINK_OK) || (state_q == ST_MISSING);
      timer_d   = (timer_run && !hb_evt_q && !timeout) ? timer_q + 16'd1 : 16'd0;

      link_ok_d = (state_d == ST_LINK_OK) || (state_d == ST_MISSING);
      fault_d   = (state_d == ST_LINK_FAIL) && (state_q != ST_LINK_FAIL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_INIT;
         timer_q   <= 16'd0;
         miss_q    <= 4'd0;
         hb_lvl_q  <= 1'b0;
         hb_evt_q  <= 1'b0;
         link_ok_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         miss_q    <= miss_d;
         hb_lvl_q  <= hb_lvl_d;
         hb_evt_q  <= hb_evt_d;
         link_ok_q <= link_ok_d;
         fault_q   <= fault_d;
      end
   end

   assign mon.mon_state   = state_q;
   assign mon.hb_link_ok  = link_ok_q;
   assign mon.hb_fault    = fault_q;
   assign mon.hb_miss_cnt = miss_q;

`ifdef HB_MON_STATS_EN
   logic [15:0] rx_cnt_q, rx_cnt_d;

   always_comb begin
      rx_cnt_d = rx_cnt_q;
      if (!enable) begin
         rx_cnt_d = 16'd0;
      end else if (hb_evt_q && (rx_cnt_q != 16'hFFFF)) begin
         rx_cnt_d = rx_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_cnt_q <= 16'd0;
      end else begin
         rx_cnt_q <= rx_cnt_d;
      end
   end

   assign mon.hb_rx_count = rx_cnt_q;
`else
   assign mon.hb_rx_count = 16'd0;
`endif

endmodule

// File: tb/tb_hb_monitor.sv
// tb/tb_hb_monitor.sv - directed and random bench for hb_monitor against a behavioural model

module tb_hb_monitor;

   localparam logic [15:0] T  = 16'd40;
   localparam logic [3:0]  ML = 4'd3;

   localparam int S_INIT = 0, S_WAIT = 1, S_OK = 2, S_MISS = 3, S_FAIL = 4, S_DIS = 5;
   localparam logic [1:0] C_BEACON = 2'b00, C_COMMIT = 2'b01, C_HB = 2'b10, C_NONE = 2'b11;

`ifdef HB_MON_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   hb_monitor_if bus ();

   hb_monitor #(.HB_TIMEOUT(T), .MISS_LIMIT(ML)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mon   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int fault_seen;

   // Behavioural reference: silence counter, miss tally and link condition.
   int m_state, m_silence, m_miss, m_cnt;
   bit m_prev_hb, m_evt, m_link, m_fault;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = S_INIT; m_silence = 0; m_miss = 0; m_cnt = 0;
      m_prev_hb = 0; m_evt = 0; m_link = 0; m_fault = 0;
   endtask

   task automatic model_step();
      bit en, hb, ev, tout, watching;
      int ns, nm;
      en = !bus.pcs_reset && bus.mr_autoneg_enable && bus.an_link_good && !bus.multidrop;
      hb = (bus.rx_cmd == C_HB);
      ev = m_evt;
      tout = (m_silence == int'(T) - 1);
      watching = (m_state == S_WAIT) || (m_state == S_OK) || (m_state == S_MISS);
      ns = m_state;
      nm = m_miss;
      if (!en) ns = S_INIT;
      else if (bus.rx_cmd == C_BEACON) ns = S_DIS;
      else if (m_state == S_INIT) begin ns = S_WAIT; nm = 0; end
      else if (m_state == S_WAIT) begin if (ev) ns = S_OK; end
      else if (ev && m_state != S_DIS) begin ns = S_OK; nm = 0; end
      else if (tout && (m_state == S_OK || m_state == S_MISS)) begin
         nm = m_miss + 1;
         if (nm >= int'(ML)) begin nm = int'(ML); ns = S_FAIL; end
         else ns = S_MISS;
      end
      m_silence = (watching && !ev && !tout) ? m_silence + 1 : 0;
      if (!en) m_cnt = 0;
      else if (ev && m_cnt < 65535) m_cnt++;
      m_fault = (ns == S_FAIL) && (m_state != S_FAIL);
      m_link  = (ns == S_OK) || (ns == S_MISS);
      m_state = ns;
      m_miss  = nm;
      m_evt   = hb && !m_prev_hb;
      m_prev_hb = hb;
   endtask

   task automatic compare_all();
      check("mon_state", bus.mon_state, m_state);
      check("hb_link_ok", bus.hb_link_ok, m_link);
      check("hb_fault", bus.hb_fault, m_fault);
      check("hb_miss_cnt", bus.hb_miss_cnt, m_miss);
      check("hb_rx_count", bus.hb_rx_count, STATS ? m_cnt : 0);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      if (bus.hb_fault === 1'b1) fault_seen++;
   endtask

   task automatic run(input int n, input logic [1:0] cmd);
      for (int i = 0; i < n; i++) begin
         bus.rx_cmd = cmd;
         cycle();
      end
   endtask

   task automatic run_until_state(input string tag, input int s, input int budget);
      int k;
      k = 0;
      bus.rx_cmd = C_NONE;
      while (m_state != s && k < budget) begin
         cycle();
         k++;
      end
      check(tag, bus.mon_state, s);
   endtask

   int miss_trace[$];
   int hb_left, gap;

   initial begin
      rst_n = 1'b0;
      bus.pcs_reset = 1'b1;
      bus.mr_autoneg_enable = 1'b0;
      bus.an_link_good = 1'b0;
      bus.multidrop = 1'b0;
      bus.rx_cmd = C_NONE;
      model_reset();
      #12;
      check("reset_state", bus.mon_state, S_INIT);
      check("reset_link", bus.hb_link_ok, 0);
      check("reset_fault", bus.hb_fault, 0);
      check("reset_miss", bus.hb_miss_cnt, 0);
      check("reset_rxcnt", bus.hb_rx_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.pcs_reset = 1'b0;
      bus.mr_autoneg_enable = 1'b1;
      bus.an_link_good = 1'b1;
      run(3, C_NONE);
      check("wait_first", bus.mon_state, S_WAIT);

      // Three-cycle heartbeat bursts well inside the timeout.
      for (int b = 0; b < 3; b++) begin
         run(3, C_HB);
         run(27, C_NONE);
      end
      check("bursts_state", bus.mon_state, S_OK);
      check("bursts_miss", bus.hb_miss_cnt, 0);
      if (STATS) check("bursts_rxcnt", bus.hb_rx_count, 3);

      // Silence until failure: misses 1,2,3 and one fault pulse.
      fault_seen = 0;
      miss_trace.delete();
      for (int i = 0; i < 3 * int'(T) + 5; i++) begin
         bus.rx_cmd = C_NONE;
         cycle();
         if (miss_trace.size() == 0 || miss_trace[$] != int'(bus.hb_miss_cnt))
            miss_trace.push_back(int'(bus.hb_miss_cnt));
      end
      check("fail_state", bus.mon_state, S_FAIL);
      check("fail_pulses", fault_seen, 1);
      check("miss_steps", miss_trace.size(), 4);
      for (int i = 0; i < miss_trace.size() && i < 4; i++)
         check("miss_seq", miss_trace[i], i);

      // Recovery from LINK_FAIL: one heartbeat, LINK_OK two cycles later.
      run(1, C_HB);
      run(1, C_NONE);
      check("recover_state", bus.mon_state, S_OK);
      check("recover_miss", bus.hb_miss_cnt, 0);

      // Heartbeat coincident with the timeout cycle in MISSING.
      run_until_state("reach_missing", S_MISS, 2 * int'(T));
      for (int k = 0; k < int'(T) && m_silence != int'(T) - 2; k++) run(1, C_NONE);
      run(1, C_HB);
      run(1, C_NONE);
      check("coinc_state", bus.mon_state, S_OK);
      check("coinc_miss", bus.hb_miss_cnt, 0);

      // BEACON disables; heartbeats ignored; loss of link good returns to INIT.
      run(1, C_BEACON);
      check("beacon_state", bus.mon_state, S_DIS);
      check("beacon_link", bus.hb_link_ok, 0);
      for (int b = 0; b < 3; b++) begin
         run(2, C_HB);
         run(20, C_NONE);
      end
      check("disabled_hold", bus.mon_state, S_DIS);
      bus.an_link_good = 1'b0;
      run(1, C_NONE);
      check("linkdown_init", bus.mon_state, S_INIT);
      bus.an_link_good = 1'b1;
      run(3, C_NONE);
      run(1, C_HB);
      run(2, C_NONE);

      // Asynchronous reset in the middle of MISSING.
      run_until_state("reach_missing2", S_MISS, 2 * int'(T));
      run(5, C_NONE);
      #2 rst_n = 1'b0;
      #1;
      check("areset_state", bus.mon_state, 0);
      check("areset_link", bus.hb_link_ok, 0);
      check("areset_fault", bus.hb_fault, 0);
      check("areset_miss", bus.hb_miss_cnt, 0);
      check("areset_rxcnt", bus.hb_rx_count, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic with occasional link drops and beacons.
      hb_left = 0;
      gap = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hb_left > 0) begin
            bus.rx_cmd = C_HB;
            hb_left--;
         end else if (gap > 0) begin
            bus.rx_cmd = ($urandom_range(0, 3) == 0) ? C_COMMIT : C_NONE;
            gap--;
         end else begin
            hb_left = $urandom_range(0, 2);
            gap = $urandom_range(5, 150);
            bus.rx_cmd = C_HB;
         end
         if ($urandom_range(0, 499) == 0) bus.rx_cmd = C_BEACON;
         bus.pcs_reset    = ($urandom_range(0, 399) == 0);
         bus.an_link_good = ($urandom_range(0, 399) != 0);
         bus.multidrop    = ($urandom_range(0, 799) == 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hb_monitor.md
HB_MONITOR -- requirements
Module: hb_monitor

Interface
REQ-001 Parameter HB_TIMEOUT, default 16'd1000, cycles without a received heartbeat before one miss is counted; legal range 2..65535.
REQ-002 Parameter MISS_LIMIT, default 4'd3, consecutive misses that declare link failure; legal range 1..15.
REQ-003 clk  input  1  block clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 pcs_reset  input  1  PCS reset, active high.
REQ-006 mr_autoneg_enable  input  1  autonegotiation enabled.
REQ-007 an_link_good  input  1  autonegotiation link good.
REQ-008 multidrop  input  1  multidrop mode; heartbeat monitoring is inactive.
REQ-009 rx_cmd  input  2  received command: 00 BEACON, 01 COMMIT, 10 HEARTBEAT, 11 NONE.
REQ-010 mon_state  output  3  current state encoding.
REQ-011 hb_link_ok  output  1  remote heartbeat present.
REQ-012 hb_fault  output  1  one-cycle pulse on entry to LINK_FAIL.
REQ-013 hb_miss_cnt  output  4  consecutive timeouts since the last heartbeat, saturating at MISS_LIMIT.
REQ-014 hb_rx_count  output  16  heartbeat event count; present only in the configuration set by REQ-034.

Function
REQ-015 The block SHALL have six states: INIT=000, WAIT_FIRST=001, LINK_OK=010, MISSING=011, LINK_FAIL=100, DISABLED=101.
REQ-016 The block SHALL define enable as: !pcs_reset && mr_autoneg_enable && an_link_good && !multidrop.
REQ-017 If enable is 0, the next state SHALL be INIT; this has the highest priority.
REQ-018 If enable is 1 and rx_cmd==BEACON, the next state SHALL be DISABLED; this has second priority.
REQ-019 DISABLED SHALL be held until enable returns to 0.
REQ-020 A heartbeat event (hb_evt) SHALL be a registered rising edge of (rx_cmd==HEARTBEAT), so a multi-cycle heartbeat counts once.
REQ-021 hb_evt SHALL be asserted 1 cycle after rx_cmd first equals HEARTBEAT.
REQ-022 INIT SHALL go to WAIT_FIRST unconditionally, clearing the timer and hb_miss_cnt.
REQ-023 The 16-bit timer SHALL increment in WAIT_FIRST, LINK_OK and MISSING.
REQ-024 The timer SHALL clear on hb_evt, on timeout, and in INIT, DISABLED and LINK_FAIL.
REQ-025 Timeout SHALL be defined as timer==HB_TIMEOUT-1.
REQ-026 WAIT_FIRST SHALL go to LINK_OK on hb_evt; WAIT_FIRST SHALL NOT count misses.
REQ-027 LINK_OK SHALL go to MISSING on timeout, setting hb_miss_cnt=1.
REQ-028 MISSING on timeout SHALL increment hb_miss_cnt; on reaching MISS_LIMIT it SHALL go to LINK_FAIL and pulse hb_fault.
REQ-029 MISSING SHALL return to LINK_OK on hb_evt, clearing hb_miss_cnt.
REQ-030 LINK_FAIL SHALL go to LINK_OK on hb_evt, clearing hb_miss_cnt.
REQ-031 If hb_evt and timeout occur in the same cycle, hb_evt SHALL win and no miss is counted.
REQ-032 hb_link_ok SHALL be 1 exactly in LINK_OK and MISSING, and SHALL be a registered output.

Reset
REQ-033 On rst_n=0, asynchronously: mon_state=INIT, hb_link_ok=0, hb_fault=0, hb_miss_cnt=0, timer=0, edge register=0, hb_rx_count=0.

Configuration
REQ-034 With macro HB_MON_STATS_EN defined:
  - hb_rx_count SHALL increment on each hb_evt while enable=1.
  - hb_rx_count SHALL saturate at 16'hFFFF.
  - hb_rx_count SHALL clear when enable=0.
  Without the macro, hb_rx_count SHALL be constant 0 and its counter SHALL NOT be instantiated.

Verification
REQ-035 Enable=1, HEARTBEAT for 3 cycles every 500 cycles, HB_TIMEOUT=1000 -> WAIT_FIRST to LINK_OK after the first edge; hb_miss_cnt stays 0; one event per burst.
REQ-036 Heartbeats stop in LINK_OK, MISS_LIMIT=3 -> MISSING after 1000 cycles; hb_miss_cnt 1,2,3; LINK_FAIL with a single hb_fault pulse at 3000 cycles.
REQ-037 In LINK_FAIL, one HEARTBEAT -> LINK_OK and hb_miss_cnt=0 two cycles later.
REQ-038 rx_cmd=BEACON in LINK_OK -> DISABLED and hb_link_ok=0; later heartbeats ignored; an_link_good=0 -> INIT.
REQ-039 hb_evt coincident with timer==HB_TIMEOUT-1 in MISSING -> LINK_OK; no increment of hb_miss_cnt.
REQ-040 rst_n low mid-MISSING, asynchronous to clk -> all outputs zero immediately; hb_rx_count 0 with and without HB_MON_STATS_EN.
